if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Parametrised IF/ID pipeline register, next generation of the fixed 32-bit fetch/decode latch.
- Adds a valid/ready handshake, a 2-entry skid buffer (so upstream ready is registered), flush with NOP insertion, and a saturating bubble counter.
- Sits between fetch (PC/instruction memory) and decode. Downstream sees either a valid instruction or a canonical NOP.

Parameters:
- PC_W, 32, width of the program counter path.
- INSTR_W, 32, width of the instruction path.
- NOP_INSTR, 32'h0000_0013, instruction driven when the stage holds no valid entry (addi x0,x0,0).
- SKID_EN, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (branch/jump redirect).
- in_valid  in  1  fetch presents a valid PC/instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_W  fetched PC.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  PC_W  PC of the head entry.
- out_instr  out  INSTR_W  instruction of the head entry, NOP_INSTR when out_valid=0.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid empty, bubble_cnt=0. in_ready=1 whenever reset is deasserted and the skid is empty. Reset mid-transfer discards all entries.
- Transfers:
  - Input transfer: in_valid & in_ready at a clk edge.
  - Output transfer: out_valid & out_ready at a clk edge.
- Latency: an input accepted at edge N appears on out_* after edge N (1 cycle) when the main register is empty or being drained.
- SKID_EN=1 states (main/skid occupancy):
  - EMPTY (0/0):
    - input transfer -> ONE.
  - ONE (1/0):
    - input + output transfer -> ONE, main loads the new entry.
    - input only -> TWO, new entry goes to skid.
    - output only -> EMPTY.
  - TWO (1/1):
    - in_ready=0 (registered, equals !skid_valid).
    - output transfer -> ONE, main loads skid contents, skid clears.
- SKID_EN=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Single register, states EMPTY/ONE only.
- Order is preserved: the skid entry is always older than any later input, and no entry is duplicated or dropped except by flush or reset.
- Flush (synchronous, highest priority after reset):
  - At the edge, main and skid valid bits clear and out_instr = NOP_INSTR.
  - out_pc holds its previous value.
  - Any input presented in the flush cycle is discarded, even if in_ready=1.
  - The next cycle in_ready=1 and the state is EMPTY.
  - An output transfer in the flush cycle still counts as consumed by decode.
- Data registers load only on their own load condition; invalid entries never change out_pc.
- bubble_cnt: +1 at each edge where out_ready=1 & out_valid=0 & flush=0. Saturates at 2^CNT_W-1 and does not wrap.
- out_valid and out_* are driven only from registers, with no combinational input-to-output path.

Test Plan:
- Reset then stream: reset low for 2 cycles; release; in_valid=1 with PC 0x0,0x4,0x8, instructions 0x00500093,0x00A00113,0x002081B3; out_ready=1 -> out_* show each entry one cycle later in order, bubble_cnt=1 (the first empty cycle).
- Backpressure/skid: load PC 0x10; drop out_ready; present PC 0x14 -> accepted into skid, in_ready=0 next cycle; hold PC 0x18 -> not accepted; raise out_ready -> outputs 0x10, 0x14, 0x18 in order, none lost or duplicated.
- Flush: in state TWO (0x20,0x24) with in_valid=1 PC 0x28, assert flush for 1 cycle -> next cycle out_valid=0, out_instr=0x00000013, in_ready=1; 0x28 never appears.
- Async reset mid-operation: in state TWO, pull reset low between edges -> out_valid=0, out_instr=NOP, bubble_cnt=0 immediately, without waiting for an edge.
- Saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and holds.
- SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> pass-through every cycle at full throughput.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, flush with NOP insertion and a saturating bubble counter.
module if_id_stage #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
  parameter bit                   SKID_EN   = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state;
  logic               ready_q;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_xfer;
  logic               out_xfer;

  // Without the skid, ONE can only be refilled while it drains, so TWO is never reached.
  assign in_ready = SKID_EN ? ready_q : (out_ready | ~out_valid);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      ready_q   <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
          end else if (in_xfer) begin
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
            ready_q    <= 1'b0;
            state      <= TWO;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            out_pc    <= skid_pc;
            out_instr <= skid_instr;
            ready_q   <= 1'b1;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !flush && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
